div_radix2: RTL and testbench



---
 rtl/div_radix2.sv | 123 ++++++++++++
 tb/tb_div_radix2.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: divides operand magnitudes,
// then sign-corrects. Returns {remainder, quotient} with a start/ready handshake.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    logic [1:0]       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic             sign_a_reg;
    logic             sign_b_reg;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign a_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign b_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign abs_a = a_neg ? (~opdata1_i + ONE) : opdata1_i;
    assign abs_b = b_neg ? (~opdata2_i + ONE) : opdata2_i;

    // The partial remainder never reaches bit WIDTH-1 before a shift, so dropping it is safe.
    assign trial   = {1'b0, rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]} - {1'b0, divisor_reg};
    assign quo_fix = (sign_a_reg ^ sign_b_reg) ? (~quo_reg + ONE) : quo_reg;
    assign rem_fix = sign_a_reg ? (~rem_reg + ONE) : rem_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            result_o    <= '0;
            ready_o     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (start_i && !annul_i) begin
                        sign_a_reg  <= a_neg;
                        sign_b_reg  <= b_neg;
                        rem_reg     <= '0;
                        quo_reg     <= abs_a;
                        divisor_reg <= abs_b;
                        cnt_reg     <= '0;
                        state_reg   <= (opdata2_i == '0) ? S_BYZERO : S_ON;
                    end
                end
                S_BYZERO: begin
                    result_o <= '0;
                    if (annul_i) begin
                        ready_o   <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        ready_o   <= 1'b1;
                        state_reg <= S_END;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        result_o  <= '0;
                        ready_o   <= 1'b0;
                        state_reg <= S_IDLE;
                    end else if (cnt_reg == CW'(WIDTH)) begin
                        result_o  <= {rem_fix, quo_fix};
                        ready_o   <= 1'b1;
                        state_reg <= S_END;
                    end else begin
                        if (trial[WIDTH]) begin
                            {rem_reg, quo_reg} <= {rem_reg[WIDTH-2:0], quo_reg, 1'b0};
                        end else begin
                            rem_reg <= trial[WIDTH-1:0];
                            quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
                        end
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                S_END: begin
                    // Result is held for EX until it drops start; a flush cannot retract it.
                    if (!start_i) begin
                        result_o  <= '0;
                        ready_o   <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    result_o  <= '0;
                    ready_o   <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_radix2.sv
// Directed, table-driven bench for div_radix2 with hand-written sequences for
// annul, asynchronous reset and result hold in END.
module tb_div_radix2;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int total = 0;
    int bad   = 0;

    div_radix2 #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // Called at posedge+1; leaves start high and returns at posedge+1 after ready (or timeout).
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int edges);
        signed_div = s;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        edges      = 0;
        res        = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                // Operands are only sampled on the start edge
                opdata1    = $urandom;
                opdata2    = $urandom;
                signed_div = ~s;
            end
            if (ready) begin
                edges = k;
                res   = result;
                break;
            end
        end
    endtask

    logic [63:0] got;
    int          lat;
    bit          saw_ready;

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,        {32'h00000002, 32'h0000000E}, 34};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34};
        vecs[2]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 34};
        vecs[3]  = '{1'b1, 32'd5,          32'd0,        64'h0,                        2};
        vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 34};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'h00000001, {32'h00000000, 32'hFFFFFFFF}, 34};
        vecs[6]  = '{1'b0, 32'd1000,       32'd3,        {32'h00000001, 32'h0000014D}, 34};
        vecs[7]  = '{1'b0, 32'hFFFFFFF9,   32'h00000002, {32'h00000001, 32'h7FFFFFFC}, 34};
        vecs[8]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, {32'hFFFFFFFF, 32'h00000003}, 34};
        vecs[9]  = '{1'b0, 32'hFFFFFFFE,   32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000000}, 34};
        vecs[10] = '{1'b0, 32'd0,          32'd5,        64'h0,                        34};

        rst        = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        start      = 1'b0;
        annul      = 1'b0;
        #3;
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, got, lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_result", i), got, vecs[i].exp);
            start = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_drop", i), {ready, result}, 65'd0);
        end

        // Annul at edge 10 of a running divide
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        start      = 1'b1;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        start = 1'b0;
        saw_ready = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) saw_ready = 1'b1;
        end
        check("annul_no_ready", {63'd0, saw_ready}, 64'd0);
        run_div(1'b0, 32'd1000, 32'd3, got, lat);
        check("restart_latency", 64'(lat), 64'd34);
        check("restart_result", got, {32'h1, 32'h14D});
        start = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of an iteration run
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        start      = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        #1 rst = 1'b0;
        #1;
        check("midon_rst_out", {ready, result}, 65'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midon_after_rst", {ready, result}, 65'd0);

        run_div(1'b0, 32'd9, 32'd3, got, lat);
        check("div9_latency", 64'(lat), 64'd34);
        check("div9_result", got, {32'h0, 32'h3});
        // Held start keeps the result; annul is ignored in END
        annul = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d", k), {ready, result}, {1'b1, 32'h0, 32'h3});
        end
        annul = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("end_async_rst", {ready, result}, 65'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
